// File: rtl/mul_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mul_pkg
//  Description : Shared types and helpers for the iterative multiplier.
//  Revision    : 1.0 - initial release
// ============================================================================
package mul_pkg;

    // Control states of the iterative multiplier
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } mul_state_t;

    // Bits needed to hold an iteration index 0..n-1 (never less than one bit)
    function automatic int cnt_width(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mul_sign_mag.sv
`default_nettype none
// ============================================================================
//  Module      : mul_sign_mag
//  Description : Converts an N-bit two's-complement value to its magnitude
//                when enabled; passes the raw value through otherwise.
//                The magnitude of the most negative value still fits in N
//                unsigned bits, so no extra width is needed.
//  Revision    : 1.0 - initial release
// ============================================================================
module mul_sign_mag #(
    parameter int N = 10
) (
    input  logic [N-1:0] a,
    input  logic         en,
    output logic [N-1:0] mag
);

    // Negate only for enabled, negative inputs
    always_comb begin
        mag = a;
        if (en && a[N-1]) begin
            mag = -a;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mul_iter.sv
`default_nettype none
// ============================================================================
//  Module      : mul_iter
//  Description : Iterative N x N multiplier consuming STEP multiplier bits
//                per cycle. Signed operands are multiplied as magnitudes and
//                the sign is restored on the final cycle. Valid/ready
//                handshakes on both input and output.
//  Revision    : 1.0 - initial release
// ============================================================================
module mul_iter
    import mul_pkg::*;
#(
    parameter int N    = 10,
    parameter int STEP = 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N-1:0]   x,
    input  logic [N-1:0]   y,
    input  logic           is_signed,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N-1:0] z,
    output logic           busy
);

    localparam int c_iters = N / STEP;
    localparam int c_cnt_w = cnt_width(c_iters);

    // Reject configurations where STEP does not divide the operand width
    generate
        if ((N % STEP) != 0) begin : g_step_check
            $error("mul_iter: N (%0d) must be a multiple of STEP (%0d)", N, STEP);
        end
    endgenerate

    mul_state_t         state_q, state_d;
    logic [N-1:0]       mcand_q, mcand_d;
    logic [N-1:0]       mplr_q, mplr_d;
    logic               neg_q, neg_d;
    logic [2*N-1:0]     acc_q, acc_d;
    logic [c_cnt_w-1:0] cnt_q, cnt_d;
    logic [2*N-1:0]     z_q, z_d;
    logic               out_valid_q, out_valid_d;

    logic [N-1:0]       w_x_mag;
    logic [N-1:0]       w_y_mag;
    logic [2*N-1:0]     w_mcand_ext;
    logic [2*N-1:0]     w_digit_ext;
    logic [31:0]        w_shamt;
    logic [2*N-1:0]     w_pp;
    logic [2*N-1:0]     w_sum;

    mul_sign_mag #(.N(N)) u_x_mag (
        .a   (x),
        .en  (is_signed),
        .mag (w_x_mag)
    );

    mul_sign_mag #(.N(N)) u_y_mag (
        .a   (y),
        .en  (is_signed),
        .mag (w_y_mag)
    );

    // Partial product of the current multiplier digit, aligned to its weight
    always_comb begin
        w_mcand_ext = {{N{1'b0}}, mcand_q};
        w_digit_ext = {{(2*N-STEP){1'b0}}, mplr_q[STEP-1:0]};
        w_shamt     = 32'(cnt_q) * 32'(STEP);
        w_pp        = (w_mcand_ext * w_digit_ext) << w_shamt;
        w_sum       = acc_q + w_pp;
    end

    // Next-state and datapath update for IDLE / CALC / DONE
    always_comb begin
        state_d     = state_q;
        mcand_d     = mcand_q;
        mplr_d      = mplr_q;
        neg_d       = neg_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        z_d         = z_q;
        out_valid_d = out_valid_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    mcand_d = w_x_mag;
                    mplr_d  = w_y_mag;
                    neg_d   = is_signed & (x[N-1] ^ y[N-1]);
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = CALC;
                end
            end
            CALC: begin
                acc_d  = w_sum;
                mplr_d = mplr_q >> STEP;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == c_cnt_w'(c_iters - 1)) begin
                    // Sign restored here; 2N-bit wrap gives the two's-complement product
                    z_d         = neg_q ? -w_sum : w_sum;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
            end
        endcase
    end

    // State and datapath registers; reset abandons any in-flight result
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            mcand_q     <= '0;
            mplr_q      <= '0;
            neg_q       <= 1'b0;
            acc_q       <= '0;
            cnt_q       <= '0;
            z_q         <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            mcand_q     <= mcand_d;
            mplr_q      <= mplr_d;
            neg_q       <= neg_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            z_q         <= z_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = (state_q == IDLE) && !rst;
    assign busy      = (state_q == CALC) || (state_q == DONE);
    assign out_valid = out_valid_q;
    assign z         = z_q;

endmodule
`default_nettype wire

// File: tb/tb_mul_iter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mul_iter
//  Description : Directed self-checking bench for mul_iter (STEP=1 and STEP=2).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mul_iter;

    localparam int N = 10;

    logic          clk;
    logic          rst;

    logic          in_valid, in_ready, is_signed, out_valid, out_ready, busy;
    logic [N-1:0]  x, y;
    logic [2*N-1:0] z;

    logic          in_valid2, in_ready2, is_signed2, out_valid2, out_ready2, busy2;
    logic [N-1:0]  x2, y2;
    logic [2*N-1:0] z2;

    int checks;
    int failures;

    mul_iter #(.N(N), .STEP(1)) u_dut1 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .x(x), .y(y), .is_signed(is_signed),
        .out_valid(out_valid), .out_ready(out_ready),
        .z(z), .busy(busy)
    );

    mul_iter #(.N(N), .STEP(2)) u_dut2 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid2), .in_ready(in_ready2),
        .x(x2), .y(y2), .is_signed(is_signed2),
        .out_valid(out_valid2), .out_ready(out_ready2),
        .z(z2), .busy(busy2)
    );

    // Free-running clock, 10 time units per period
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One full transaction on either DUT with out_ready held high.
    // Called 1 time unit after a rising edge.
    task automatic run(input bit b, input string tag, input logic [N-1:0] xa,
                       input logic [N-1:0] ya, input logic sg,
                       input logic [31:0] exp_z, input int exp_lat);
        int  lat;
        bit  ctl_bad;
        logic v, r, bz;
        lat     = 0;
        ctl_bad = 1'b0;
        if (b) begin
            x2 = xa; y2 = ya; is_signed2 = sg; in_valid2 = 1'b1;
        end else begin
            x = xa; y = ya; is_signed = sg; in_valid = 1'b1;
        end
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        in_valid2 = 1'b0;
        // Scramble operands after accept; they must not matter any more
        x = '1; y = '1; is_signed = ~sg;
        x2 = '1; y2 = '1; is_signed2 = ~sg;
        for (int k = 1; k <= 30; k++) begin
            v  = b ? out_valid2 : out_valid;
            r  = b ? in_ready2  : in_ready;
            bz = b ? busy2      : busy;
            if (r !== 1'b0 || bz !== 1'b1) ctl_bad = 1'b1;
            @(posedge clk);
            #1;
            v = b ? out_valid2 : out_valid;
            if (v === 1'b1) begin
                lat = k;
                break;
            end
        end
        check({tag, "_ctl"}, 32'(ctl_bad), 32'd0);
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check({tag, "_z"}, 32'(b ? z2 : z), exp_z);
        @(posedge clk);
        #1;
        check({tag, "_ovld_after"}, 32'(b ? out_valid2 : out_valid), 32'd0);
        check({tag, "_rdy_after"}, 32'(b ? in_ready2 : in_ready), 32'd1);
    endtask

    initial begin
        int  lat;
        bit  bad;
        checks    = 0;
        failures  = 0;
        rst       = 1'b1;
        in_valid  = 1'b0; x  = '0; y  = '0; is_signed  = 1'b0; out_ready  = 1'b1;
        in_valid2 = 1'b0; x2 = '0; y2 = '0; is_signed2 = 1'b0; out_ready2 = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_ovld", 32'(out_valid), 32'd0);
        check("rst_z", 32'(z), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        #1;
        check("rst_rdy", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;

        // Unsigned
        run(1'b0, "u_3x5",       10'd3,    10'd5,    1'b0, 32'h0000F, 10);
        run(1'b0, "u_max",       10'd1023, 10'd1023, 1'b0, 32'hFF801, 10);
        run(1'b0, "u_zero",      10'd0,    10'd1023, 1'b0, 32'h00000, 10);
        run(1'b0, "u_3fdx7",     10'h3FD,  10'd7,    1'b0, 32'h01BEB, 10);
        // Signed
        run(1'b0, "s_m3x7",      10'h3FD,  10'd7,    1'b1, 32'hFFFEB, 10);
        run(1'b0, "s_m512xm512", 10'h200,  10'h200,  1'b1, 32'h40000, 10);
        run(1'b0, "s_m512x1",    10'h200,  10'd1,    1'b1, 32'hFFE00, 10);

        // Backpressure: hold the result for 5 cycles while offering new operands
        out_ready = 1'b0;
        x = 10'd6; y = 10'd7; is_signed = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 0;
        for (int k = 1; k <= 30; k++) begin
            @(posedge clk);
            #1;
            if (out_valid === 1'b1) begin
                lat = k;
                break;
            end
        end
        check("bp_lat", 32'(lat), 32'd10);
        bad = 1'b0;
        x = 10'd1; y = 10'd1;
        for (int k = 0; k < 5; k++) begin
            in_valid = k[0];
            @(posedge clk);
            #1;
            if (out_valid !== 1'b1 || z !== 20'd42 || in_ready !== 1'b0) bad = 1'b1;
        end
        in_valid = 1'b0;
        check("bp_hold", 32'(bad), 32'd0);
        check("bp_z", 32'(z), 32'd42);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_release_ovld", 32'(out_valid), 32'd0);
        check("bp_release_rdy", 32'(in_ready), 32'd1);
        check("bp_z_retained", 32'(z), 32'd42);
        run(1'b0, "bp_next", 10'd2, 10'd9, 1'b0, 32'd18, 10);

        // Reset in the middle of a calculation
        x = 10'd100; y = 10'd3; is_signed = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("mid_rst_ovld", 32'(out_valid), 32'd0);
        check("mid_rst_z", 32'(z), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("mid_rst_rdy", 32'(in_ready), 32'd1);
        bad = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk);
            #1;
            if (out_valid !== 1'b0 || busy !== 1'b0) bad = 1'b1;
        end
        check("mid_rst_no_stale", 32'(bad), 32'd0);
        run(1'b0, "post_rst_3x5", 10'd3, 10'd5, 1'b0, 32'h0000F, 10);

        // Two bits per cycle
        run(1'b1, "s2_100x200", 10'd100, 10'd200, 1'b0, 32'd20000, 5);
        run(1'b1, "s2_m3x7",    10'h3FD, 10'd7,   1'b1, 32'hFFFEB, 5);
        run(1'b1, "s2_max",     10'd1023, 10'd1023, 1'b0, 32'hFF801, 5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mul_iter.md
Name: mul_iter

Overview:
- Iterative, parametrised successor to the combinational cascade multiplier.
- Multiplies two N-bit operands using STEP multiplier bits per clock cycle, and supports both unsigned and signed (two's-complement) operation.
- Uses valid/ready handshakes on input and output, so it can sit in a datapath as a backpressure-aware, area-reduced multiplier stage.

Parameters:
- N, 10, operand width in bits; product is 2N bits.
- STEP, 1, multiplier bits consumed per CALC cycle; N % STEP == 0 is required (elaboration-time $error otherwise).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand offer.
- in_ready  output  1  block can accept operands (high only in IDLE).
- x  input  N  multiplicand.
- y  input  N  multiplier.
- is_signed  input  1  1 = treat x, y as two's complement; sampled with operands.
- out_valid  output  1  z holds a valid product.
- out_ready  input  1  downstream accepts z.
- z  output  2N  product (registered).
- busy  output  1  high in CALC or DONE.

Behaviour:
- Reset (async, rst=1): state=IDLE, z=0, out_valid=0, busy=0, internal accumulator/counter/operands=0. in_ready=1 once rst deasserts.
- Reset mid-operation: any state goes to IDLE immediately; the in-flight result is discarded and never presented.
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - in_ready=1.
  - On edge with in_valid=1, capture mcand=|x| and mplr=|y| (magnitudes when is_signed=1, raw otherwise).
  - Capture neg = is_signed & (x[N-1]^y[N-1]).
  - Clear acc (2N bits) and cnt; go to CALC.
- CALC:
  - in_ready=0.
  - Each cycle: acc += (mcand * mplr[STEP-1:0]) << (cnt*STEP); mplr >>= STEP; cnt++.
  - On the cycle where cnt == N/STEP-1, the final partial product is added and the sign correction is applied: z <= neg ? -(acc+pp) : acc+pp (2N-bit wrap).
  - Then go to DONE.
- DONE:
  - out_valid=1, z stable.
  - On edge with out_ready=1: out_valid<=0, go to IDLE.
  - z retains its last value after the handshake until the next result is written.
- Latency: operands accepted at edge T, out_valid first high after edge T+N/STEP. Throughput is one result per N/STEP+2 cycles, assuming out_ready=1.
- Magnitude of -2^(N-1) is 2^(N-1), which fits in N unsigned bits; the max magnitude product 2^(2N-2) fits in 2N bits, so no overflow is possible.
- in_valid during CALC/DONE is ignored (no capture); the upstream must hold its offer.
- out_ready while out_valid=0 has no effect.
- Simultaneous out_ready and in_valid in DONE: only the output handshake completes. The new operands are accepted the following cycle in IDLE; there is no back-to-back overlap.
- x, y, is_signed are sampled only at the accept edge; later changes have no effect.

Decomposition:
- Package mul_pkg:
  - typedef enum logic [1:0] {IDLE, CALC, DONE} mul_state_t.
  - Helper function for the ceil-log2 width of the cycle counter.
- Sub-module mul_sign_mag (combinational): N-bit two's-complement to magnitude when enabled.
  - Instantiated twice at operand capture.
  - The final negate stays inline.
- The remainder (FSM, accumulator, counter) lives in mul_iter.

Test Plan:
- N=10, STEP=1, unsigned: x=3, y=5 -> out_valid exactly 10 cycles after accept edge, z=15; in_ready=0 and busy=1 throughout.
- Unsigned extremes: x=1023, y=1023 -> z=1046529; x=0, y=1023 -> z=0.
- Signed mode:
  - x=-3 (0x3FD), y=7 -> z=0xFFFEB (-21).
  - x=-512, y=-512 -> z=262144.
  - x=-512, y=1 -> z=0xFFE00.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid -> z and out_valid stable, in_ready=0, in_valid pulses ignored. Then out_ready=1 -> IDLE next cycle, and the following accept works.
- Reset mid-CALC: assert rst 4 cycles after accept -> out_valid=0, z=0, in_ready=1 after release, no stale result emitted. Then re-run 3*5 -> z=15.
- STEP=2 build (N=10): x=100, y=200 -> z=20000 with 5-cycle latency. Build with STEP=3 -> elaboration error.
